// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Posted-write buffer between the MIPS memory-access stage and a byte-addressed,
// little-endian data memory that reads combinationally and writes on posedge.
// Stores are queued in a small circular FIFO and retire to memory in cycles
// without a load. Loads read memory directly, but a load that hits a queued
// store is served from the youngest matching entry.
//
// Parameters:
//   DEPTH     number of buffered stores (power of two, >= 2)
//   PW        pointer width, log2(DEPTH)
//
// Ports:
//   clk       system clock, all state updates on posedge
//   rst_n     asynchronous active-low reset; queued stores are discarded
//   adr       datapath byte address (adr[1:0] ignored, word accesses only)
//   d_in      datapath store data
//   mrd       datapath load request (level)
//   mwr       datapath store request (level)
//   d_out     load data to datapath (combinational, 0 when no load)
//   stall     store refused this cycle because the buffer is full
//   empty     no buffered stores
//   mem_adr   word-aligned memory address
//   mem_din   memory write data
//   mem_mrd   memory read enable
//   mem_mwr   memory write enable
//   mem_dout  memory read data
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] adr,
    input  logic [31:0] d_in,
    input  logic        mrd,
    input  logic        mwr,
    output logic [31:0] d_out,
    output logic        stall,
    output logic        empty,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_din,
    output logic        mem_mrd,
    output logic        mem_mwr,
    input  logic [31:0] mem_dout
);

    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    // Entry storage: word address and data per slot.
    logic [29:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    logic          full;
    logic          load;
    logic          enq;
    logic          deq;
    logic          fwd_hit;
    logic [31:0]   fwd_data;

    // Byte-offset bits of the address are intentionally ignored.
    logic          unused_adr_bits;
    assign unused_adr_bits = ^adr[1:0];

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Reset forces the load path quiet even if mrd is asserted.
    assign load  = mrd & rst_n;

    // A full buffer refuses the store even if a drain frees a slot this cycle;
    // the datapath re-presents it next cycle.
    assign stall = mwr & full;
    assign enq   = mwr & ~full;

    // Loads own the memory port; stores retire only in load-free cycles.
    assign deq   = ~mrd & ~empty;

    // Youngest-match search: walk oldest to youngest so later hits override.
    // The entry being written this cycle is not yet in the array, so a
    // simultaneous load sees the buffer as it stood before the store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((PW+1)'(i) < count) &&
                (addr_q[head + PW'(i)] == adr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[head + PW'(i)];
            end
        end
    end

    // Memory-side port and datapath read data.
    always_comb begin
        mem_mrd = load;
        mem_mwr = deq;
        mem_adr = '0;
        mem_din = '0;
        d_out   = '0;
        if (load) begin
            mem_adr = {adr[31:2], 2'b00};
            d_out   = fwd_hit ? fwd_data : mem_dout;
        end else if (deq) begin
            mem_adr = {addr_q[head], 2'b00};
            mem_din = data_q[head];
        end
    end

    // NOTE: the entry array carries no reset; validity is defined purely by
    // head/count, so clearing the pointers is enough and keeps the array a
    // plain register file without reset muxes.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail] <= adr[31:2];
            data_q[tail] <= d_in;
        end
    end

    // Pointers and occupancy. Pointer increments wrap naturally at DEPTH
    // because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//
// Table-driven bench for store_buffer. Each table row is one clock cycle of
// datapath inputs plus the hand-computed outputs expected during that cycle.
// A behavioural data memory (combinational read, posedge write) is attached
// to the memory port. Unwritten memory words read as 0xC0DE0000 | word_index.
// Hand-written sequences cover asynchronous reset mid-operation and the final
// memory contents.
// -----------------------------------------------------------------------------
module tb_store_buffer;

    logic        clk;
    logic        rst_n;
    logic [31:0] adr;
    logic [31:0] d_in;
    logic        mrd;
    logic        mwr;
    logic [31:0] d_out;
    logic        stall;
    logic        empty;
    logic [31:0] mem_adr;
    logic [31:0] mem_din;
    logic        mem_mrd;
    logic        mem_mwr;
    logic [31:0] mem_dout;

    int n_cmp = 0;
    int n_bad = 0;

    store_buffer #(.DEPTH(4), .PW(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .adr      (adr),
        .d_in     (d_in),
        .mrd      (mrd),
        .mwr      (mwr),
        .d_out    (d_out),
        .stall    (stall),
        .empty    (empty),
        .mem_adr  (mem_adr),
        .mem_din  (mem_din),
        .mem_mrd  (mem_mrd),
        .mem_mwr  (mem_mwr),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- data memory model ----------------
    logic [31:0]   mem [1024];
    logic [1023:0] wr_seen;
    logic          init_n;
    logic [9:0]    widx;

    assign widx     = mem_adr[11:2];
    assign mem_dout = wr_seen[widx] ? mem[widx] : (32'hC0DE_0000 | {22'd0, widx});

    always @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            wr_seen <= '0;
        end else if (mem_mwr) begin
            mem[widx]     <= mem_din;
            wr_seen[widx] <= 1'b1;
        end
    end

    function automatic logic [31:0] mem_word(input int idx);
        logic [9:0] i10;
        i10 = idx[9:0];
        return wr_seen[i10] ? mem[i10] : (32'hC0DE_0000 | {22'd0, i10});
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        mrd;
        logic        mwr;
        logic [31:0] adr;
        logic [31:0] d_in;
        logic        stall;
        logic        empty;
        logic        mmrd;
        logic        mmwr;
        logic [31:0] madr;
        logic [31:0] mdin;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs[$];

    function automatic void mk(input logic m_rd, input logic m_wr,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic e_stall, input logic e_empty,
                               input logic e_mmrd, input logic e_mmwr,
                               input logic [31:0] e_madr, input logic [31:0] e_mdin,
                               input logic [31:0] e_dout);
        vec_t v;
        v.mrd = m_rd;  v.mwr = m_wr;  v.adr = a;  v.d_in = d;
        v.stall = e_stall; v.empty = e_empty; v.mmrd = e_mmrd; v.mmwr = e_mmwr;
        v.madr = e_madr; v.mdin = e_mdin; v.dout = e_dout;
        vecs.push_back(v);
    endfunction

    initial begin
        rst_n  = 1'b0;
        init_n = 1'b0;
        mrd    = 1'b0;
        mwr    = 1'b0;
        adr    = '0;
        d_in   = '0;

        //  mrd mwr  adr   d_in     stall empty mmrd mmwr madr  mdin   dout
        // Reset then idle
        mk(0, 0, 0,    0,        0, 1, 0, 0, 0,    0,     0);
        mk(0, 0, 0,    0,        0, 1, 0, 0, 0,    0,     0);
        mk(0, 0, 0,    0,        0, 1, 0, 0, 0,    0,     0);
        // Single store then drain
        mk(0, 1, 1000, 'h1234,   0, 1, 0, 0, 0,    0,     0);
        mk(0, 0, 0,    0,        0, 0, 0, 1, 1000, 'h1234, 0);
        mk(0, 0, 0,    0,        0, 1, 0, 0, 0,    0,     0);
        // Forwarding, youngest hit
        mk(1, 1, 2000, 'hA,      0, 1, 1, 0, 2000, 0,     'hC0DE01F4);
        mk(1, 1, 2000, 'hB,      0, 0, 1, 0, 2000, 0,     'hA);
        mk(1, 0, 2000, 0,        0, 0, 1, 0, 2000, 0,     'hB);
        mk(1, 0, 2004, 0,        0, 0, 1, 0, 2004, 0,     'hC0DE01F5);
        mk(0, 0, 0,    0,        0, 0, 0, 1, 2000, 'hA,   0);
        mk(0, 0, 0,    0,        0, 0, 0, 1, 2000, 'hB,   0);
        mk(0, 0, 0,    0,        0, 1, 0, 0, 0,    0,     0);
        mk(1, 0, 2000, 0,        0, 1, 1, 0, 2000, 0,     'hB);
        // Full and stall (loads held so nothing drains)
        mk(1, 1, 1000, 'h11,     0, 1, 1, 0, 1000, 0,     'h1234);
        mk(1, 1, 1004, 'h22,     0, 0, 1, 0, 1004, 0,     'hC0DE00FB);
        mk(1, 1, 1008, 'h33,     0, 0, 1, 0, 1008, 0,     'hC0DE00FC);
        mk(1, 1, 1012, 'h44,     0, 0, 1, 0, 1012, 0,     'hC0DE00FD);
        mk(1, 1, 1016, 'h55,     1, 0, 1, 0, 1016, 0,     'hC0DE00FE);
        mk(1, 1, 1016, 'h55,     1, 0, 1, 0, 1016, 0,     'hC0DE00FE);
        mk(0, 1, 1016, 'h55,     1, 0, 0, 1, 1000, 'h11,  0);
        mk(0, 1, 1016, 'h55,     0, 0, 0, 1, 1004, 'h22,  0);
        mk(0, 0, 0,    0,        0, 0, 0, 1, 1008, 'h33,  0);
        mk(0, 0, 0,    0,        0, 0, 0, 1, 1012, 'h44,  0);
        mk(0, 0, 0,    0,        0, 0, 0, 1, 1016, 'h55,  0);
        mk(0, 0, 0,    0,        0, 1, 0, 0, 0,    0,     0);
        // Simultaneous load+store to the same address
        mk(0, 1, 1076, 'h5,      0, 1, 0, 0, 0,    0,     0);
        mk(1, 1, 1076, 'h9,      0, 0, 1, 0, 1076, 0,     'h5);
        mk(1, 0, 1076, 0,        0, 0, 1, 0, 1076, 0,     'h9);
        mk(0, 0, 0,    0,        0, 0, 0, 1, 1076, 'h5,   0);
        mk(0, 0, 0,    0,        0, 0, 0, 1, 1076, 'h9,   0);
        mk(0, 0, 0,    0,        0, 1, 0, 0, 0,    0,     0);
        mk(1, 0, 1076, 0,        0, 1, 1, 0, 1076, 0,     'h9);

        // Outputs while reset is held, with a load requested.
        #2;
        init_n = 1'b1;
        mrd    = 1'b1;
        adr    = 32'd1000;
        #1;
        check("in_reset.empty", {31'd0, empty}, 32'd1);
        check("in_reset.dout", d_out, 32'd0);
        check("in_reset.mem_mrd", {31'd0, mem_mrd}, 32'd0);
        check("in_reset.mem_mwr", {31'd0, mem_mwr}, 32'd0);
        mrd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            mrd  = vecs[i].mrd;
            mwr  = vecs[i].mwr;
            adr  = vecs[i].adr;
            d_in = vecs[i].d_in;
            #1;
            check($sformatf("row%0d.stall", i),   {31'd0, stall},   {31'd0, vecs[i].stall});
            check($sformatf("row%0d.empty", i),   {31'd0, empty},   {31'd0, vecs[i].empty});
            check($sformatf("row%0d.mem_mrd", i), {31'd0, mem_mrd}, {31'd0, vecs[i].mmrd});
            check($sformatf("row%0d.mem_mwr", i), {31'd0, mem_mwr}, {31'd0, vecs[i].mmwr});
            check($sformatf("row%0d.mem_adr", i), mem_adr,          vecs[i].madr);
            check($sformatf("row%0d.mem_din", i), mem_din,          vecs[i].mdin);
            check($sformatf("row%0d.dout", i),    d_out,            vecs[i].dout);
        end

        // Reset mid-operation: queue three stores under a held load, then
        // pulse reset between clock edges.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mrd  = 1'b1;
            mwr  = 1'b1;
            adr  = 32'd1100 + 32'(4 * k);
            d_in = 32'hE0 + 32'(k);
        end
        @(negedge clk);
        mwr = 1'b0;
        adr = 32'd1100;
        #1;
        check("mid_rst.pre_empty", {31'd0, empty}, 32'd0);
        check("mid_rst.pre_fwd", d_out, 32'hE0);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst.empty", {31'd0, empty}, 32'd1);
        check("mid_rst.dout", d_out, 32'd0);
        check("mid_rst.mem_mrd", {31'd0, mem_mrd}, 32'd0);
        check("mid_rst.mem_mwr", {31'd0, mem_mwr}, 32'd0);
        check("mid_rst.stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;
        mrd   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("post_rst%0d.mem_mwr", k), {31'd0, mem_mwr}, 32'd0);
            check($sformatf("post_rst%0d.empty", k), {31'd0, empty}, 32'd1);
        end
        check("mem_1100", mem_word(275), 32'hC0DE0113);
        check("mem_1104", mem_word(276), 32'hC0DE0114);
        check("mem_1108", mem_word(277), 32'hC0DE0115);

        // Final memory contents from the drained stores.
        check("mem_1000", mem_word(250), 32'h11);
        check("mem_1004", mem_word(251), 32'h22);
        check("mem_1016", mem_word(254), 32'h55);
        check("mem_2000", mem_word(500), 32'hB);
        check("mem_1076", mem_word(269), 32'h9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
